// File: rtl/spi_sequencer_if.sv
// Signal bundle between spi_sequencer and its host/message controller.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface spi_sequencer_if;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic msg_bit;
  logic last_bit;
  logic last_msg;
  logic inc_bit;
  logic inc_msg;
  logic index_clear;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;

  modport slave (
    input  start, abort, msg_bit, last_bit, last_msg,
    output busy, done, inc_bit, inc_msg, index_clear,
           spi_sclk, spi_cs_n, spi_mosi
  );

  modport master (
    output start, abort, msg_bit, last_bit, last_msg,
    input  busy, done, inc_bit, inc_msg, index_clear,
           spi_sclk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_sequencer.sv
// SPI mode-0 timing engine: steps a message controller bit by bit and drives
// registered SCLK/CS_N/MOSI with programmable divide, CS setup/hold and gap.
module spi_sequencer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1,
  parameter int unsigned MSG_GAP  = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  spi_sequencer_if.slave bus
);

  localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_CD = (CS_HOLD > MSG_GAP) ? CS_HOLD : MSG_GAP;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MSG_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             inc_bit_raw;
  logic             inc_msg_raw;
  logic             active;

  assign active = (state_q != S_IDLE);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    inc_bit_raw = 1'b0;
    inc_msg_raw = 1'b0;

    // Strobes come from state and counter alone; last_* only pick the branch.
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SETUP;
      S_SETUP: if (cnt_q == SETUP_LAST) state_d = S_LOW;
      S_LOW:   if (cnt_q == DIV_LAST) state_d = S_HIGH;
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          inc_bit_raw = 1'b1;
          state_d     = bus.last_bit ? S_HOLD : S_LOW;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          inc_msg_raw = 1'b1;
          state_d     = bus.last_msg ? S_DONE : S_GAP;
        end
      end
      S_GAP:   if (cnt_q == GAP_LAST) state_d = S_SETUP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && active) state_d = S_IDLE;
  end

  // The phase counter restarts on every state change and rests at 0 in IDLE.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = '0;
  end

  // Pins are registered from the next state so CS_N/SCLK line up with state_q.
  always_comb begin
    cs_n_d = !(state_d inside {S_SETUP, S_LOW, S_HIGH, S_HOLD});
    sclk_d = (state_d == S_HIGH);
    unique case (state_q)
      S_SETUP, S_LOW: mosi_d = bus.msg_bit;
      S_HIGH, S_HOLD: mosi_d = mosi_q;
      default:        mosi_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  // An abort in the same cycle as a strobe wins: the indices get cleared instead.
  assign bus.inc_bit     = inc_bit_raw && !bus.abort;
  assign bus.inc_msg     = inc_msg_raw && !bus.abort;
  assign bus.index_clear = bus.abort && active;
  assign bus.busy        = active;
  assign bus.done        = (state_q == S_DONE);
  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_mosi    = mosi_q;

endmodule
